// File: rtl/cnt_pwm_gen.sv
// cnt_pwm_gen
//
// Purpose:
//   This block turns the count from an upstream free-running counter into a
//   PWM waveform.
//   - A new duty value is written into a one-deep pending register. It becomes
//     the active duty only at the start of a period, so a period never changes
//     duty part-way through.
//   - A period starts when cnt wraps to 0. A one-cycle period_tick follows
//     each wrap.
//
// Optional feature (macro CNT_PWM_COMP_EN):
//   Adds the complementary output pwm_out_n. A four-state machine holds both
//   outputs low for DEAD cycles around every edge.
//   Without the macro, pwm_out is the registered compare result and the
//   pwm_out_n port does not exist.
//
// Parameters:
//   WIDTH  width of cnt and duty; the period is 2**WIDTH cycles
//   DEAD   dead-time cycles per edge, must be >= 1 (used only with CNT_PWM_COMP_EN)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   cnt          in   count from the upstream counter (same clock domain)
//   duty_wr      in   write strobe for duty_in
//   duty_in      in   requested number of high counts per period
//   duty_busy    out  pending register is full; writes are ignored while set
//   duty_ack     out  one-cycle pulse when the pending duty becomes active
//   period_tick  out  one-cycle pulse, one cycle after cnt reaches 0 from a non-zero value
//   pwm_out      out  PWM output (high side when CNT_PWM_COMP_EN is defined)
//   pwm_out_n    out  complementary output (only with CNT_PWM_COMP_EN)
module cnt_pwm_gen #(
  parameter int WIDTH = 8,
  parameter int DEAD  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic             duty_wr,
  input  logic [WIDTH-1:0] duty_in,
  output logic             duty_busy,
  output logic             duty_ack,
  output logic             period_tick,
`ifdef CNT_PWM_COMP_EN
  output logic             pwm_out,
  output logic             pwm_out_n
`else
  output logic             pwm_out
`endif
);

  if (DEAD < 1) begin : g_dead_check
    $error("cnt_pwm_gen: DEAD must be at least 1");
  end

  logic [WIDTH-1:0] cnt_p1;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] duty_act;
  logic             raw_p1;
  logic             start_p0;
  logic [WIDTH-1:0] duty_sel_p0;

  // ---- stage p0: period-start detect and duty selection (combinational) ----
  // cnt_p1 resets to all ones. The first cnt == 0 after reset is therefore a
  // start. A cnt held at 0 produces only one start.
  assign start_p0    = (cnt == '0) && (cnt_p1 != '0);
  // The first count of a period must already use the duty that is being
  // applied in that same cycle.
  assign duty_sel_p0 = (start_p0 && duty_busy) ? pend : duty_act;

  // ---- stage p1: registered compare, tick and duty handshake ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1      <= '1;
      period_tick <= 1'b0;
      raw_p1      <= 1'b0;
      pend        <= '0;
      duty_act    <= '0;
      duty_busy   <= 1'b0;
      duty_ack    <= 1'b0;
    end else begin
      cnt_p1      <= cnt;
      period_tick <= start_p0;
      raw_p1      <= (cnt < duty_sel_p0);
      duty_ack    <= 1'b0;
      // Apply takes priority. A write that arrives while busy is dropped,
      // because busy is sampled before the clock edge.
      if (start_p0 && duty_busy) begin
        duty_act  <= pend;
        duty_busy <= 1'b0;
        duty_ack  <= 1'b1;
      end else if (duty_wr && !duty_busy) begin
        pend      <= duty_in;
        duty_busy <= 1'b1;
      end
    end
  end

`ifdef CNT_PWM_COMP_EN
  typedef enum logic [1:0] {S_LO, S_DT_LH, S_HI, S_DT_HL} state_t;
  localparam int DW = $clog2(DEAD + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;

  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    case (state)
      S_LO: begin
        if (raw_p1) begin
          state_nxt = S_DT_LH;
          dead_nxt  = DW'(DEAD);
        end
      end
      S_HI: begin
        if (!raw_p1) begin
          state_nxt = S_DT_HL;
          dead_nxt  = DW'(DEAD);
        end
      end
      default: begin
        // Dead time lasts DEAD cycles. The raw level present at expiry picks
        // the next side, so raw pulses shorter than DEAD are absorbed.
        if (dead_cnt <= DW'(1)) begin
          state_nxt = raw_p1 ? S_HI : S_LO;
        end else begin
          dead_nxt = dead_cnt - DW'(1);
        end
      end
    endcase
  end

  // ---- stage p2: dead-time state and registered outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DT_HL;
      dead_cnt  <= DW'(DEAD);
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      dead_cnt  <= dead_nxt;
      pwm_out   <= (state_nxt == S_HI);
      pwm_out_n <= (state_nxt == S_LO);
    end
  end
`else
  assign pwm_out = raw_p1;
`endif

endmodule
